encode_64b_67b: RTL
===================

ENCODE_64B_67B -- requirements
Module: encode_64B_67B

Interface
REQ-001 SHALL have no parameters; word size 67, lane width 80 and buffer depth 147 bits fixed.
REQ-002 USER_CLK  in  1  single clock; all state on rising edge.
REQ-003 SYSTEM_RESET_N  in  1  asynchronous, active-low reset.
REQ-004 DATA_IN  in  64  payload word.
REQ-005 HEADER_IN  in  2  sync header; 2'b01 data, 2'b10 control.
REQ-006 DATA_IN_VALID  in  1  DATA_IN/HEADER_IN valid.
REQ-007 DATA_IN_READY  out  1  word accepted on a cycle with VALID&&READY.
REQ-008 DATA_OUT  out  80  lane word, earliest-transmitted bit at bit 0.
REQ-009 DATA_OUT_VALID  out  1  DATA_OUT holds 80 encoded bits.
REQ-010 DATA_OUT_READY  in  1  downstream consumes DATA_OUT when VALID&&READY.
REQ-011 HEADER_ERR  out  1  registered one-cycle pulse: accepted word had header 2'b00 or 2'b11.

Function
REQ-012 Each accepted word SHALL form a 67-bit frame: bit 66 inversion flag, bits 65:64 HEADER_IN unmodified, bits 63:0 DATA_IN, or ~DATA_IN when flag=1.
REQ-013 Frames SHALL pack LSB-first into a 147-bit shift buffer with fill count cnt (0..147); the new frame occupies bits starting at position cnt (after any same-cycle emit).
REQ-014 DATA_OUT SHALL equal buffer[79:0]; DATA_OUT_VALID = (cnt >= 80), both driven directly from registers.
REQ-015 emit = DATA_OUT_VALID && DATA_OUT_READY; on emit buffer shifts right 80 and cnt -= 80.
REQ-016 DATA_IN_READY = ((cnt - (emit ? 80 : 0)) <= 80), combinational from cnt and DATA_OUT_READY.
REQ-017 Simultaneous emit and accept SHALL apply both same edge: cnt' = cnt - 80 + 67.
REQ-018 Accepted frame's bits SHALL appear on DATA_OUT no earlier than the cycle after acceptance; no bits dropped, duplicated or reordered.
REQ-019 Running disparity rd SHALL be 8-bit signed, reset 0; w = 2*popcount(DATA_IN) - 64.
REQ-020 Flag SHALL be 1 iff (rd > 0 && w > 0) or (rd < 0 && w < 0); rd=0 or w=0 -> flag 0.
REQ-021 On accept rd' = rd + (flag ? -w : w) + (flag ? 1 : -1); header contributes 0; rd unchanged otherwise.
REQ-022 Invalid headers SHALL still be encoded and transmitted unmodified, HEADER_ERR pulsing next cycle.
REQ-023 DATA_IN_VALID low SHALL leave buffer contents and rd untouched; DATA_OUT_READY low SHALL hold DATA_OUT stable.

Reset
REQ-024 Reset assertion SHALL immediately force cnt=0, rd=0, buffer=0, DATA_OUT=0, DATA_OUT_VALID=0, HEADER_ERR=0; partially packed frames discarded.
REQ-025 DATA_IN_READY SHALL be 1 during and after reset (cnt=0).
REQ-026 First accept permitted on first rising edge after deassertion.

Configuration
REQ-027 Macro ENCODE_DISPARITY_EN defined: inversion per REQ-020/021.
REQ-028 Macro undefined: flag always 0, data never inverted, rd logic absent; packing and handshake identical.

Structure
REQ-029 Shared package SHALL hold constants FRAME_W=67, LANE_W=80, BUF_W=147, HDR_DATA=2'b01, HDR_CTRL=2'b10.
REQ-030 Disparity calculation (popcount, flag, rd update) SHALL be sub-module disparity_64B_67B; packing/handshake in top.

Verification
REQ-031 Reset, send words 0..N continuously, DATA_OUT_READY=1 -> DATA_OUT_VALID first at cycle after 2nd accept; chaining DATA_OUT into decode_64B_67B (valid tied high) reaches LOCKED after 64 good headers, decoded data/headers match input in order.
REQ-032 Macro on, rd=0, send 64'hFFFF_FFFF_FFFF_FFFF hdr 01 twice -> frame1 flag 0 (rd=+63), frame2 flag 1, data 0, rd=+0.
REQ-033 DATA_OUT_READY=0 with continuous input -> READY drops once cnt=134 (2 frames); no data lost after READY reasserts.
REQ-034 Header 2'b11 accepted -> HEADER_ERR one-cycle pulse, frame bits 65:64 = 2'b11 on output.
REQ-035 Assert SYSTEM_RESET_N low mid-stream with cnt=54 -> DATA_OUT_VALID=0, DATA_OUT=0 immediately; post-reset stream starts at bit 0 with rd=0.
REQ-036 Macro off, send 64'hFFFF_FFFF_FFFF_FFFF repeatedly -> bit 66 always 0, data never inverted.

Source files
------------

// File: rtl/encode_64b_67b_pkg.sv
// Shared constants, frame layout and helpers for the 64b/67b encoder.
package encode_64b_67b_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned FRAME_W = 67;
  localparam int unsigned LANE_W  = 80;
  localparam int unsigned BUF_W   = 147;
  localparam int unsigned CNT_W   = 8;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  // Fill-count versions of the widths, sized to the counter.
  localparam logic [CNT_W-1:0] FRAME_CNT = 8'd67;
  localparam logic [CNT_W-1:0] LANE_CNT  = 8'd80;

  // Bit 66 inversion flag, bits 65:64 sync header, bits 63:0 payload.
  typedef struct packed {
    logic              inv;
    logic [1:0]        hdr;
    logic [DATA_W-1:0] payload;
  } frame_t;

  function automatic logic [6:0] popcount64(input logic [DATA_W-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/encode_64b_67b_disparity.sv
// Running-disparity tracker: decides per-word inversion and updates rd on accept.
module disparity_64B_67B
  import encode_64b_67b_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              flag_o
);

  logic signed [7:0] rd_q, rd_d;
  logic signed [7:0] w;
  logic        [6:0] pc;

  // Word weight, inversion decision and next running disparity (wraps at 8 bits).
  always_comb begin
    pc     = popcount64(data_i);
    w      = $signed({pc, 1'b0}) - 8'sd64;
    flag_o = ((rd_q > 8'sd0) && (w > 8'sd0)) || ((rd_q < 8'sd0) && (w < 8'sd0));
    rd_d   = rd_q;
    if (accept_i) begin
      rd_d = rd_q + (flag_o ? -w : w) + (flag_o ? 8'sd1 : -8'sd1);
    end
  end

  // Disparity register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

endmodule

// File: rtl/encode_64b_67b.sv
// 64b/67b encoder: frames each word, packs frames LSB-first into a 147-bit
// shift buffer and emits 80-bit lane words. Optional running-disparity
// inversion is built when ENCODE_DISPARITY_EN is defined.
module encode_64b_67b
  import encode_64b_67b_pkg::*;
(
  input  logic              USER_CLK,
  input  logic              SYSTEM_RESET_N,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [1:0]        HEADER_IN,
  input  logic              DATA_IN_VALID,
  output logic              DATA_IN_READY,
  output logic [LANE_W-1:0] DATA_OUT,
  output logic              DATA_OUT_VALID,
  input  logic              DATA_OUT_READY,
  output logic              HEADER_ERR
);

  logic [BUF_W-1:0] buffer_q, buffer_d, buf_sh;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sh;
  logic             out_valid_q, out_valid_d;
  logic             hdr_err_q, hdr_err_d;
  logic             emit, accept, in_ready, inv_flag;
  frame_t           frame;

`ifdef ENCODE_DISPARITY_EN
  disparity_64B_67B u_disp (
    .clk      (USER_CLK),
    .rst_n    (SYSTEM_RESET_N),
    .accept_i (accept),
    .data_i   (DATA_IN),
    .flag_o   (inv_flag)
  );
`else
  assign inv_flag = 1'b0;
`endif

  // Drain side first: the post-emit fill level decides whether a frame fits.
  always_comb begin
    emit     = out_valid_q && DATA_OUT_READY;
    cnt_sh   = emit ? (cnt_q - LANE_CNT) : cnt_q;
    buf_sh   = emit ? (buffer_q >> LANE_W) : buffer_q;
    in_ready = (cnt_sh <= LANE_CNT);
    accept   = DATA_IN_VALID && in_ready;
  end

  // Build the frame and append it just above the surviving bits. Bits above
  // the fill count are always zero, so an OR is enough to merge.
  always_comb begin
    frame.inv     = inv_flag;
    frame.hdr     = HEADER_IN;
    frame.payload = inv_flag ? ~DATA_IN : DATA_IN;
    buffer_d      = buf_sh;
    cnt_d         = cnt_sh;
    if (accept) begin
      buffer_d = buf_sh | ({{(BUF_W-FRAME_W){1'b0}}, frame} << cnt_sh);
      cnt_d    = cnt_sh + FRAME_CNT;
    end
    out_valid_d = (cnt_d >= LANE_CNT);
    hdr_err_d   = accept && (HEADER_IN != HDR_DATA) && (HEADER_IN != HDR_CTRL);
  end

  // Packing state; reset discards any partially packed frames.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      buffer_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      buffer_q    <= buffer_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  assign DATA_IN_READY  = in_ready;
  assign DATA_OUT       = buffer_q[LANE_W-1:0];
  assign DATA_OUT_VALID = out_valid_q;
  assign HEADER_ERR     = hdr_err_q;

endmodule
